seven_seg_scanner: RTL



---
 rtl/seg_pkg.sv | 31 +++
 rtl/seven_seg_decode.sv | 18 +
 rtl/seven_seg_scanner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit positions, the hex glyph
// table and the pin polarity helper used by the scanner and decoder.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high A..G patterns, indexed by nibble value (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] seg_polarity(input logic [7:0] active_high,
                                               input logic       active_low);
    logic [7:0] pins;
    if (active_low) begin
      pins = ~active_high;
    end else begin
      pins = active_high;
    end
    return pins;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex-to-segment decoder producing the active-high glyph
// (A..G in bits 0..6, decimal point in bit 7).
module seven_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] glyph
);

  // Table lookup plus decimal point.
  always_comb begin
    glyph         = 8'h00;
    glyph[6:0]    = HEX_GLYPH[nibble];
    glyph[SEG_DP] = dp;
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with frame-latched inputs,
// one dead cycle per digit slot, leading-zero blanking and a frame strobe.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_blank,
  output logic [7:0]                ssd,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_tick
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0] SSD_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};

  logic [PRE_W-1:0]          pre_r;
  logic [IDX_W-1:0]          idx_r;
  logic [4*NUM_DIGITS-1:0]   sh_value_r;
  logic [NUM_DIGITS-1:0]     sh_dp_r;
  logic [NUM_DIGITS-1:0]     sh_en_r;
  logic                      sh_lz_r;
  logic [7:0]                ssd_r;
  logic [NUM_DIGITS-1:0]     an_r;

  logic                      frame_start_s;
  logic                      zero_above_s;
  logic [NUM_DIGITS-1:0]     blank_s;
  logic [3:0]                nib_s;
  logic                      dp_sel_s;
  logic                      show_s;
  logic [7:0]                glyph_s;
  logic [7:0]                ssd_hi_s;
  logic [NUM_DIGITS-1:0]     an_hi_s;

  assign frame_start_s = (pre_r == {PRE_W{1'b0}}) && (idx_r == {IDX_W{1'b0}});
  assign frame_tick    = frame_start_s & ~rst;
  assign ssd           = ssd_r;
  assign an            = an_r;

  // A digit is blanked when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    blank_s      = {NUM_DIGITS{1'b0}};
    zero_above_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s & (sh_value_r[4*k +: 4] == 4'h0);
      blank_s[k]   = sh_lz_r & zero_above_s & (k != 0);
    end
  end

  // Select the active digit from the frame shadow.
  always_comb begin
    nib_s    = sh_value_r[{idx_r, 2'b00} +: 4];
    dp_sel_s = sh_dp_r[idx_r] & ~blank_s[idx_r];
    show_s   = sh_en_r[idx_r] & ~blank_s[idx_r] & (pre_r != {PRE_W{1'b0}});
  end

  seven_seg_decode u_decode (
    .nibble (nib_s),
    .dp     (dp_sel_s),
    .glyph  (glyph_s)
  );

  // Active-high next outputs; dead-time, disabled and blanked slots stay dark.
  always_comb begin
    an_hi_s  = {NUM_DIGITS{1'b0}};
    ssd_hi_s = 8'h00;
    if (show_s) begin
      an_hi_s[idx_r] = 1'b1;
      ssd_hi_s       = glyph_s;
    end else begin
      an_hi_s  = {NUM_DIGITS{1'b0}};
      ssd_hi_s = 8'h00;
    end
  end

  // Prescaler, digit index, frame shadow and registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r      <= {PRE_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      sh_value_r <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_r    <= {NUM_DIGITS{1'b0}};
      sh_en_r    <= {NUM_DIGITS{1'b0}};
      sh_lz_r    <= 1'b0;
      an_r       <= AN_OFF;
      ssd_r      <= SSD_OFF;
    end else begin
      if (pre_r == PRE_LAST) begin
        pre_r <= {PRE_W{1'b0}};
        if (idx_r == IDX_LAST) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end else begin
        pre_r <= pre_r + PRE_W'(1);
      end
      if (frame_start_s) begin
        sh_value_r <= value;
        sh_dp_r    <= dp_in;
        sh_en_r    <= digit_en;
        sh_lz_r    <= lz_blank;
      end else begin
        sh_lz_r    <= sh_lz_r;
      end
      an_r  <= an_hi_s ^ AN_OFF;
      ssd_r <= seg_polarity(ssd_hi_s, ACTIVE_LOW != 0);
    end
  end

endmodule
